// File: rtl/vga_fetch_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vga_fetch_arbiter_pkg
// Shared constants for the VGA tile-number prefetch arbiter:
//   - line geometry (super-pixel columns/rows, tile number width)
//   - fetch FSM state encoding
//   - memory slot owner encoding
// ---------------------------------------------------------------------------
package vga_fetch_arbiter_pkg;

    // Line geometry
    localparam int COLS  = 32;   // super-pixels per row
    localparam int ROWS  = 16;   // super-pixel rows per frame
    localparam int PIC_W = 9;    // tile number width
    localparam int COL_W = 5;    // column index width
    localparam int ROW_W = 4;    // row index width

    // Fetch FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    // Owner of the memory slot currently presented on the memory port
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_CPU   = 2'd1;
    localparam logic [1:0] OWN_FETCH = 2'd2;

endpackage

// File: rtl/vga_fetch_arbiter_line_buffer.sv
// ---------------------------------------------------------------------------
// vga_line_buffer
// Double-buffered tile-number line store: 2 banks x COLS entries x PIC_W.
// Ports:
//   clk, reset          clock, synchronous active-low reset (read register only)
//   wrEn/wrBank/wrCol   synchronous write of wrData into [wrBank][wrCol]
//   rdBank/rdCol        read address; rdData is registered (1-cycle latency)
// Storage contents are deliberately not cleared by reset.
// ---------------------------------------------------------------------------
module vga_line_buffer
    import vga_fetch_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic             wrBank,
    input  logic [COL_W-1:0] wrCol,
    input  logic [PIC_W-1:0] wrData,
    input  logic             rdBank,
    input  logic [COL_W-1:0] rdCol,
    output logic [PIC_W-1:0] rdData
);

    logic [PIC_W-1:0] store_r [0:2*COLS-1];
    logic [PIC_W-1:0] rd_data_r;

    // Write port: one captured tile number per fetch slot
    always_ff @(posedge clk) begin
        if (wrEn) begin
            store_r[{wrBank, wrCol}] <= wrData;
        end
    end

    // Registered read port feeding the pixel path
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_r <= {PIC_W{1'b0}};
        end else begin
            rd_data_r <= store_r[{rdBank, rdCol}];
        end
    end

    assign rdData = rd_data_r;

endmodule

// File: rtl/vga_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fetch_arbiter
// Shares the single tile-map memory port between CPU accesses and the VGA
// tile-number prefetch, which fills one super-pixel row ahead of the beam
// into the non-display bank of a double-buffered line buffer.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   frameStart                  vblank pulse: latch startAddress/rowLength, fetch row 0
//   rowStart, rowIdx            row boundary: swap banks, fetch row rowIdx+1
//   startAddress, rowLength     tile-map origin and stride
//   xSupPix -> PicNum           display-bank read, 1-cycle latency
//   rowReady, underrun          fetch-bank complete / row arrived too early
//   cpuReq/cpuWe/cpuAddr/cpuWData -> cpuAck/cpuRData   CPU access handshake
//   memAddr/memWe/memWData, memRData                   memory port
// ---------------------------------------------------------------------------
module vga_fetch_arbiter
    import vga_fetch_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameStart,
    input  logic              rowStart,
    input  logic [ROW_W-1:0]  rowIdx,
    input  logic [ADDR_W-1:0] startAddress,
    input  logic [ADDR_W-1:0] rowLength,
    input  logic [COL_W-1:0]  xSupPix,
    output logic [PIC_W-1:0]  PicNum,
    output logic              rowReady,
    output logic              underrun,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWData,
    output logic              cpuAck,
    output logic [DATA_W-1:0] cpuRData,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W:0]   COLS_CNT = (COL_W + 1)'(COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    // Fetch sequencing state
    logic [0:0]        state_r;
    logic [COL_W:0]    issue_col_r;     // next column to issue, COLS when all issued
    logic [ADDR_W-1:0] row_base_r;      // tile-map address of the row being fetched
    logic [ADDR_W-1:0] row_len_r;       // latched stride
    logic              disp_bank_r;     // fetch bank is always the other one
    logic              fill_done_r;     // last capture happened on the previous edge

    // Memory slot state
    logic [1:0]        owner_r;         // owner of the slot now on the memory port
    logic [COL_W-1:0]  cap_col_r;       // column of the fetch slot now on the port
    logic              cpu_turn_r;      // next contested slot goes to the CPU
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_r;
    logic [DATA_W-1:0] mem_wdata_r;

    // Status / CPU response registers
    logic              cpu_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic              row_ready_r;
    logic              underrun_r;

    // Per-cycle decisions
    logic              frame_go_s;
    logic              row_ev_s;
    logic              row_go_s;
    logic              start_fetch_s;
    logic              kill_s;
    logic              fetch_elig_s;
    logic              cpu_elig_s;
    logic              grant_cpu_s;
    logic              grant_fetch_s;
    logic              capture_s;
    logic              last_capture_s;
    logic [ADDR_W-1:0] fetch_addr_s;

    // Event qualification and memory slot arbitration
    always_comb begin
        frame_go_s     = frameStart;
        // frameStart takes precedence over a coincident rowStart
        row_ev_s       = rowStart && !frameStart;
        row_go_s       = row_ev_s && (rowIdx < LAST_ROW);
        start_fetch_s  = frame_go_s || row_go_s;
        // Any frame or row boundary discards the capture in flight; the fetch
        // either restarts at column 0 or stops (last row)
        kill_s         = frame_go_s || row_ev_s;
        fetch_elig_s   = (state_r == ST_FETCH) && (issue_col_r < COLS_CNT) && !kill_s;
        // CPU may not re-issue while its op is on the port or being acked
        cpu_elig_s     = cpuReq && (owner_r != OWN_CPU) && !cpu_ack_r;
        capture_s      = (owner_r == OWN_FETCH) && !kill_s;
        last_capture_s = capture_s && (cap_col_r == LAST_COL);
        fetch_addr_s   = row_base_r + {{(ADDR_W - COL_W){1'b0}}, issue_col_r[COL_W-1:0]};

        if (cpu_elig_s && (!fetch_elig_s || cpu_turn_r)) begin
            grant_cpu_s   = 1'b1;
            grant_fetch_s = 1'b0;
        end else if (fetch_elig_s) begin
            grant_cpu_s   = 1'b0;
            grant_fetch_s = 1'b1;
        end else begin
            grant_cpu_s   = 1'b0;
            grant_fetch_s = 1'b0;
        end
    end

    // Row fetch sequencing: start/abort, column issue counter, bank swap
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            issue_col_r <= {(COL_W + 1){1'b0}};
            row_base_r  <= {ADDR_W{1'b0}};
            row_len_r   <= {ADDR_W{1'b0}};
            disp_bank_r <= 1'b0;
            fill_done_r <= 1'b0;
        end else begin
            if (frame_go_s) begin
                row_base_r <= startAddress;
                row_len_r  <= rowLength;
            end else if (row_go_s) begin
                row_base_r <= row_base_r + row_len_r;
            end

            if (row_ev_s) begin
                disp_bank_r <= ~disp_bank_r;
            end

            if (start_fetch_s) begin
                state_r     <= ST_FETCH;
                issue_col_r <= {(COL_W + 1){1'b0}};
            end else if (row_ev_s) begin
                // Final row of the frame: nothing further to prefetch
                state_r     <= ST_IDLE;
                issue_col_r <= {(COL_W + 1){1'b0}};
            end else begin
                if (grant_fetch_s) begin
                    issue_col_r <= issue_col_r + 6'd1;
                end
                if (last_capture_s) begin
                    state_r <= ST_IDLE;
                end
            end

            fill_done_r <= last_capture_s;
        end
    end

    // Memory port: register the granted slot and track its owner
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdata_r <= {DATA_W{1'b0}};
            owner_r     <= OWN_NONE;
            cap_col_r   <= {COL_W{1'b0}};
            cpu_turn_r  <= 1'b0;
        end else begin
            if (grant_cpu_s) begin
                mem_addr_r  <= cpuAddr;
                mem_we_r    <= cpuWe;
                mem_wdata_r <= cpuWData;
                owner_r     <= OWN_CPU;
            end else if (grant_fetch_s) begin
                mem_addr_r  <= fetch_addr_s;
                mem_we_r    <= 1'b0;
                owner_r     <= OWN_FETCH;
                cap_col_r   <= issue_col_r[COL_W-1:0];
            end else begin
                mem_we_r    <= 1'b0;
                owner_r     <= OWN_NONE;
            end

            if (cpu_elig_s && fetch_elig_s) begin
                cpu_turn_r <= ~cpu_turn_r;
            end
        end
    end

    // CPU response: ack the cycle after its slot, returning read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= {DATA_W{1'b0}};
        end else begin
            cpu_ack_r <= (owner_r == OWN_CPU);
            if ((owner_r == OWN_CPU) && !mem_we_r) begin
                cpu_rdata_r <= memRData;
            end
        end
    end

    // Status flags: row completion and early row arrival
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_ready_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            underrun_r <= row_ev_s && (state_r == ST_FETCH);
            if (start_fetch_s) begin
                row_ready_r <= 1'b0;
            end else if (fill_done_r) begin
                row_ready_r <= 1'b1;
            end
        end
    end

    vga_line_buffer u_line_buffer (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (capture_s && reset),
        .wrBank (~disp_bank_r),
        .wrCol  (cap_col_r),
        .wrData (memRData[PIC_W-1:0]),
        .rdBank (disp_bank_r),
        .rdCol  (xSupPix),
        .rdData (PicNum)
    );

    assign rowReady = row_ready_r;
    assign underrun = underrun_r;
    assign cpuAck   = cpu_ack_r;
    assign cpuRData = cpu_rdata_r;
    assign memAddr  = mem_addr_r;
    assign memWe    = mem_we_r;
    assign memWData = mem_wdata_r;

endmodule
